edge_detector: RTL and testbench

Debounces a noisy asynchronous mechanical input (push-button/switch) on a single clock domain and produces a clean level plus a one-cycle pulse on each debounced rising edge. It sits between a board-level button pin and control logic that must act once per press. The default configuration is a 100 MHz clock with a 20 ms stability window.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/edge_detector.sv | 71 +++++++
 tb/tb_edge_detector.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// ============================================================================
// Module : debounce_pkg
// Brief  : Shared constants and width helper for the button debouncer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 2000000;
    localparam int CLK_FREQ_HZ             = 100000000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_DEBOUNCE_CYCLES);

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer with synchronous active-high reset to 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/edge_detector.sv
// ============================================================================
// Module : edge_detector
// Brief  : Debounces a noisy input; emits a clean level and a rising pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module edge_detector
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic noisy,
    output logic debounced,
    output logic edge_trig
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_in;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;
    logic             trig_q;
    logic             trig_d;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (noisy),
        .q_o   (sync_in)
    );

    // Any sample agreeing with the current level restarts the window.
    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        trig_d = 1'b0;
        if (sync_in == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            deb_d  = sync_in;
            cnt_d  = '0;
            trig_d = sync_in;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            deb_q  <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            trig_q <= trig_d;
        end
    end

    assign debounced = deb_q;
    assign edge_trig = trig_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_detector.sv
// ============================================================================
// Module : tb_edge_detector
// Brief  : Segment-table bench for edge_detector with a small debounce window.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_edge_detector;

    localparam int C_DEB = 16;

    typedef struct {
        logic rst;
        logic noisy;
        int   cycles;
        logic exp_deb;
        int   exp_rises;
    } vec_t;

    typedef struct {
        int   idx;
        logic exp_deb;
        int   exp_rises;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic noisy = 1'b0;
    logic debounced;
    logic edge_trig;

    int checks   = 0;
    int failures = 0;
    int rises    = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    edge_detector #(
        .DEBOUNCE_CYCLES (C_DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .noisy     (noisy),
        .debounced (debounced),
        .edge_trig (edge_trig)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (edge_trig === 1'b1) rises++;
    endtask

    task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s seg=%0d actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s seg=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic n, input int c, input logic d, input int e);
        vec_t v;
        v.rst = r; v.noisy = n; v.cycles = c; v.exp_deb = d; v.exp_rises = e;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;

        // Reset, then quiet input.
        add(1, 0,   2, 0, 0);
        add(0, 0, 100, 0, 0);
        // Short bounce never reaches the output.
        add(0, 1,  10, 0, 0);
        add(0, 0,  10, 0, 0);
        // Clean press: level flips on the 18th edge after the change.
        add(0, 1,  17, 0, 0);
        add(0, 1,   1, 1, 1);
        add(0, 1,  20, 1, 0);
        // Release with glitch; falls 18 edges after the final 1->0.
        add(0, 0,   8, 1, 0);
        add(0, 1,   3, 1, 0);
        add(0, 0,  17, 1, 0);
        add(0, 0,   1, 0, 0);
        add(0, 0,  20, 0, 0);
        // Window boundary: 15-cycle pulse rejected, 16-cycle pulse accepted.
        add(0, 1,  15, 0, 0);
        add(0, 0,  20, 0, 0);
        add(0, 1,  16, 0, 0);
        add(0, 0,   2, 1, 1);
        add(0, 0,  30, 0, 0);
        // Reset mid-count discards progress; rise 18 edges after reset edge.
        add(0, 1,  12, 0, 0);
        add(1, 1,   1, 0, 0);
        add(0, 1,  17, 0, 0);
        add(0, 1,   1, 1, 1);
        add(0, 1,  40, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            noisy = vecs[i].noisy;
            e.idx = i; e.exp_deb = vecs[i].exp_deb; e.exp_rises = vecs[i].exp_rises;
            sb.push_back(e);
            rises = 0;
            repeat (vecs[i].cycles) tick();
            e = sb.pop_front();
            check_bit("debounced", e.idx, debounced, e.exp_deb);
            check_int("edge_pulses", e.idx, rises, e.exp_rises);
        end

        // Hand sequence: pulse is exactly one cycle wide on a fresh press.
        reset = 1'b0;
        noisy = 1'b0;
        repeat (25) tick();
        check_bit("pre_press_level", 100, debounced, 1'b0);
        noisy = 1'b1;
        repeat (17) tick();
        check_bit("trig_before", 101, edge_trig, 1'b0);
        tick();
        check_bit("trig_at_rise", 102, edge_trig, 1'b1);
        check_bit("level_at_rise", 102, debounced, 1'b1);
        tick();
        check_bit("trig_after", 103, edge_trig, 1'b0);

        // Hand sequence: falling transition never pulses.
        noisy = 1'b0;
        rises = 0;
        repeat (17) tick();
        check_bit("level_before_fall", 104, debounced, 1'b1);
        tick();
        check_bit("level_after_fall", 105, debounced, 1'b0);
        check_bit("trig_on_fall", 105, edge_trig, 1'b0);
        check_int("fall_pulses", 105, rises, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
